// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_DEV,
    ST_SUB_HI,
    ST_ACK_HI,
    ST_SUB_LO,
    ST_ACK_LO,
    ST_WR_DATA,
    ST_ACK_WR,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } sccb_state_t;

  localparam logic SCCB_DIR_WRITE = 1'b0;
  localparam logic SCCB_DIR_READ  = 1'b1;
  localparam int   SCCB_SUBADDR_W = 16;
  localparam int   SCCB_BYTE_BITS = 8;

endpackage

// File: rtl/sccb_sync_edge.sv
// Multi-flop synchroniser with a one-flop edge detector for an SCCB line.
module sccb_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to the idle-high bus level so no phantom edge follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/sccb_slave.sv
// SCCB responder with a synchronous register-file port.
// Optional: define SCCB_SLAVE_ACK_DRIVE_EN to drive an I2C-style ACK on the 9th bit of written bytes.
module sccb_slave
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h1C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sio_c,
  input  logic                      sio_d_in,
  output logic                      sio_d_oe,
  output logic [SCCB_SUBADDR_W-1:0] reg_addr,
  output logic [7:0]                reg_wdata,
  output logic                      reg_we,
  input  logic [7:0]                reg_rdata,
  output logic                      busy
);

`ifdef SCCB_SLAVE_ACK_DRIVE_EN
  localparam logic ACK_DRIVE = 1'b1;
`else
  localparam logic ACK_DRIVE = 1'b0;
`endif

  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
  logic start, stop, last_bit;

  sccb_state_t state, state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n, tx, tx_n, sub_hi, sub_hi_n, byte_in;
  logic        dir, dir_n;
  logic [SCCB_SUBADDR_W-1:0] addr_n;
  logic [7:0]  wdata_n;
  logic        we_n, oe_n, busy_n;

  sccb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_c (
    .clk(clk), .reset(reset), .raw(sio_c), .level(scl), .rise(scl_rise), .fall(scl_fall)
  );
  sccb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_d (
    .clk(clk), .reset(reset), .raw(sio_d_in), .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  assign start    = sda_fall & scl;
  assign stop     = sda_rise & scl;
  assign last_bit = (bit_cnt == 3'(SCCB_BYTE_BITS - 1));
  assign byte_in  = {shift[6:0], sda};

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    tx_n      = tx;
    sub_hi_n  = sub_hi;
    dir_n     = dir;
    addr_n    = reg_addr;
    wdata_n   = reg_wdata;
    we_n      = 1'b0;
    oe_n      = sio_d_oe;
    busy_n    = busy;
    // Bus conditions take priority over any bit activity in the same cycle.
    if (start) begin
      state_n   = ST_DEV_ADDR;
      bit_cnt_n = '0;
      oe_n      = 1'b0;
      busy_n    = 1'b1;
    end else if (stop) begin
      state_n   = ST_IDLE;
      bit_cnt_n = '0;
      oe_n      = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        ST_DEV_ADDR, ST_SUB_HI, ST_SUB_LO, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_n   = byte_in;
            bit_cnt_n = bit_cnt + 3'd1;
            if (last_bit) begin
              case (state)
                ST_DEV_ADDR: begin
                  dir_n   = byte_in[0];
                  state_n = (byte_in[7:1] == DEV_ADDR) ? ST_ACK_DEV : ST_IGNORE;
                end
                ST_SUB_HI: begin
                  sub_hi_n = byte_in;
                  state_n  = ST_ACK_HI;
                end
                ST_SUB_LO: begin
                  addr_n  = {sub_hi, byte_in};
                  state_n = ST_ACK_LO;
                end
                default: begin
                  wdata_n = byte_in;
                  we_n    = 1'b1;
                  state_n = ST_ACK_WR;
                end
              endcase
            end
          end
        end
        // bit_cnt 0 waits for the 8th falling edge, 1 waits for the 9th.
        ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO, ST_ACK_WR: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              bit_cnt_n = 3'd1;
              oe_n      = ACK_DRIVE;
            end else begin
              bit_cnt_n = '0;
              oe_n      = 1'b0;
              case (state)
                ST_ACK_DEV: begin
                  if (dir == SCCB_DIR_READ) begin
                    state_n = ST_RD_DATA;
                    oe_n    = ~reg_rdata[7];
                    tx_n    = {reg_rdata[6:0], 1'b0};
                  end else begin
                    state_n = ST_SUB_HI;
                  end
                end
                ST_ACK_HI: state_n = ST_SUB_LO;
                ST_ACK_LO: state_n = ST_WR_DATA;
                default: begin
                  state_n = ST_WR_DATA;
                  addr_n  = reg_addr + 1'b1;
                end
              endcase
            end
          end
        end
        // Bit 7 is already on the bus at entry; each fall shifts the next out.
        ST_RD_DATA: begin
          if (scl_fall) begin
            if (last_bit) begin
              oe_n      = 1'b0;
              bit_cnt_n = '0;
              state_n   = ST_RD_ACK;
            end else begin
              oe_n      = ~tx[7];
              tx_n      = {tx[6:0], 1'b0};
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda) begin
              state_n = ST_IGNORE;
            end else begin
              addr_n    = reg_addr + 1'b1;
              bit_cnt_n = 3'd1;
            end
          end else if (scl_fall && bit_cnt == 3'd1) begin
            bit_cnt_n = '0;
            oe_n      = ~reg_rdata[7];
            tx_n      = {reg_rdata[6:0], 1'b0};
            state_n   = ST_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      dir       <= SCCB_DIR_WRITE;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      sio_d_oe  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      dir       <= dir_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_we    <= we_n;
      sio_d_oe  <= oe_n;
      busy      <= busy_n;
    end
  end

  always_ff @(posedge clk) begin
    shift  <= shift_n;
    tx     <= tx_n;
    sub_hi <= sub_hi_n;
  end

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: a bit-banged SCCB master, a write monitor and a read-back register model.
module tb_sccb_slave;

  localparam int Q = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sio_c = 1'b1;
  logic        sda_m = 1'b1;
  logic        sio_d_in;
  logic        sio_d_oe;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic [7:0]  reg_rdata;
  logic        busy;

  assign sio_d_in  = sda_m & ~sio_d_oe;
  assign reg_rdata = reg_addr[7:0] ^ 8'h6E;

  always #5 clk = ~clk;

  sccb_slave #(.DEV_ADDR(7'h1C), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sio_c(sio_c), .sio_d_in(sio_d_in), .sio_d_oe(sio_d_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_rdata(reg_rdata), .busy(busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  logic        oe_seen = 1'b0;
  logic [15:0] wq_addr[$];
  logic [7:0]  wq_data[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (reg_we) begin
        we_cnt++;
        wq_addr.push_back(reg_addr);
        wq_data.push_back(reg_wdata);
      end
      if (sio_d_oe) oe_seen = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    we_cnt  = 0;
    oe_seen = 1'b0;
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #Q;
    sio_c = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    sio_c = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q;
    sio_c = 1'b1; #Q;
    sda_m = 1'b1; #(4*Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q;
    sio_c = 1'b1; #(2*Q);
    sio_c = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(1'b1);
  endtask

  task automatic read_byte(output logic [7:0] data, output logic [7:0] oe_pat, input logic nack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #Q;
      sio_c = 1'b1; #Q;
      data[i]   = sio_d_in;
      oe_pat[i] = sio_d_oe;
      #Q;
      sio_c = 1'b0; #Q;
    end
    send_bit(nack);
  endtask

  task automatic wr_txn(input logic [7:0] dev, input logic [15:0] sub, input int n,
                        input logic [7:0] d0, input logic [7:0] d1);
    bus_start();
    chk("busy_after_start", busy, 1'b1);
    send_byte(dev);
    send_byte(sub[15:8]);
    send_byte(sub[7:0]);
    if (n > 0) send_byte(d0);
    if (n > 1) send_byte(d1);
    bus_stop();
  endtask

  typedef struct {
    logic [7:0]  dev;
    logic [15:0] sub;
    logic [7:0]  data;
    int          exp_we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd, pat;

    vecs[0] = '{8'h38, 16'h1234, 8'hAA, 1, 16'h1234, 8'hAA};
    vecs[1] = '{8'h42, 16'h5678, 8'h55, 0, 16'h0000, 8'h00};
    vecs[2] = '{8'h38, 16'h0001, 8'h00, 1, 16'h0001, 8'h00};
    vecs[3] = '{8'h38, 16'hBEEF, 8'hFF, 1, 16'hBEEF, 8'hFF};
    vecs[4] = '{8'h3A, 16'h1111, 8'h77, 0, 16'h0000, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe", sio_d_oe, 1'b0);
    chk("rst_we", reg_we, 1'b0);
    chk("rst_addr", reg_addr, 16'h0000);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk) reset = 1'b0;
    #(4*Q);

    for (int v = 0; v < 5; v++) begin
      clr_mon();
      wr_txn(vecs[v].dev, vecs[v].sub, 1, vecs[v].data, 8'h00);
      chk($sformatf("vec%0d_we_count", v), we_cnt, vecs[v].exp_we);
      if (vecs[v].exp_we == 1 && wq_addr.size() > 0) begin
        chk($sformatf("vec%0d_addr", v), wq_addr[0], vecs[v].exp_addr);
        chk($sformatf("vec%0d_wdata", v), wq_data[0], vecs[v].exp_data);
      end
      chk($sformatf("vec%0d_busy_after_stop", v), busy, 1'b0);
      chk($sformatf("vec%0d_oe_never", v), oe_seen, 1'b0);
    end

    // Pointer wrap across a two-byte burst.
    clr_mon();
    wr_txn(8'h38, 16'hFFFF, 2, 8'h11, 8'h22);
    chk("wrap_we_count", we_cnt, 2);
    if (wq_addr.size() >= 2) begin
      chk("wrap_addr0", wq_addr[0], 16'hFFFF);
      chk("wrap_data0", wq_data[0], 8'h11);
      chk("wrap_addr1", wq_addr[1], 16'h0000);
      chk("wrap_data1", wq_data[1], 8'h22);
    end

    // Pointer set by write phase, then a two-byte read ending in NA.
    clr_mon();
    wr_txn(8'h38, 16'h1234, 0, 8'h00, 8'h00);
    chk("rdset_we_count", we_cnt, 0);
    chk("rdset_addr", reg_addr, 16'h1234);
    bus_start();
    send_byte(8'h39);
    read_byte(rd, pat, 1'b0);
    chk("rd0_data", rd, 8'h5A);
    chk("rd0_oe_pattern", pat, 8'hA5);
    read_byte(rd, pat, 1'b1);
    chk("rd1_data", rd, 8'h5B);
    chk("rd1_oe_pattern", pat, 8'hA4);
    #(4*Q);
    chk("rd_na_oe", sio_d_oe, 1'b0);
    chk("rd_na_busy", busy, 1'b1);
    oe_seen = 1'b0;
    send_byte(8'h00);
    chk("rd_ignore_oe", oe_seen, 1'b0);
    bus_stop();
    chk("rd_busy_after_stop", busy, 1'b0);
    chk("rd_addr_after", reg_addr, 16'h1235);

    // STOP part-way through the low sub-address byte.
    clr_mon();
    wr_txn(8'h38, 16'h4321, 0, 8'h00, 8'h00);
    chk("part_addr_set", reg_addr, 16'h4321);
    bus_start();
    send_byte(8'h38);
    send_byte(8'h12);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    chk("part_we_count", we_cnt, 0);
    chk("part_addr_kept", reg_addr, 16'h4321);
    chk("part_busy", busy, 1'b0);

    // Reset while driving the first read bit.
    wr_txn(8'h38, 16'h0010, 0, 8'h00, 8'h00);
    bus_start();
    send_byte(8'h39);
    chk("rst_mid_oe_before", sio_d_oe, 1'b1);
    chk("rst_mid_busy_before", busy, 1'b1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_oe", sio_d_oe, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    @(negedge clk) reset = 1'b0;
    sda_m = 1'b1;
    sio_c = 1'b1;
    #(4*Q);
    clr_mon();
    wr_txn(8'h38, 16'h2222, 1, 8'h99, 8'h00);
    chk("post_rst_we_count", we_cnt, 1);
    if (wq_addr.size() > 0) begin
      chk("post_rst_addr", wq_addr[0], 16'h2222);
      chk("post_rst_wdata", wq_data[0], 8'h99);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sccb_slave.md
Name: sccb_slave

Overview:
- SCCB responder (camera-side register port) that answers the existing SCCB master in the same design.
- Oversamples the master's sio_c/sio_d on the system clock and decodes 3-phase writes (device address, 16-bit sub-address, data) and 2-phase reads.
- Presents a simple synchronous register-file interface.
- Used as a sensor model in simulation and as an on-FPGA configuration target; the top level builds the open-drain pad from sio_d_oe.

Parameters:
- DEV_ADDR, 7'h1C: 7-bit device address this block answers to.
- SYNC_STAGES, 2: synchroniser depth on sio_c and sio_d (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the sio_c rate.
- reset  in  1  synchronous, active-high reset.
- sio_c  in  1  SCCB clock from the master.
- sio_d_in  in  1  SCCB data as seen at the pad.
- sio_d_oe  out  1  1 pulls sio_d low; 0 releases it (pull-up).
- reg_addr  out  16  register pointer (current sub-address).
- reg_wdata  out  8  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_rdata  in  8  read data for reg_addr; combinational, valid in the same cycle.
- busy  out  1  high from START until STOP.

Behaviour:
- Synchronisation and edge detection
  - Both inputs pass through SYNC_STAGES flops, then a one-flop edge detector.
  - All decode uses the synchronised versions only.
- Bus conditions
  - START: sio_d falls while sio_c is high.
  - STOP: sio_d rises while sio_c is high.
  - Data bits are sampled on the sio_c rising edge, MSB first.
  - The slave changes sio_d_oe only in the cycle after a detected sio_c falling edge.
- Reset values: sio_d_oe=0, reg_we=0, reg_addr=0, reg_wdata=0, busy=0, state=IDLE.
  - Reset applies on the next clk edge, including mid-transfer.
- States: IDLE, DEV_ADDR, ACK_DEV, SUB_HI, ACK_HI, SUB_LO, ACK_LO, WR_DATA, ACK_WR, RD_DATA, RD_ACK, IGNORE.
- IDLE -> DEV_ADDR on START; bit counter cleared, busy=1.
- DEV_ADDR: after 8 bits, compare [7:1] with DEV_ADDR.
  - Mismatch -> IGNORE.
  - Match, bit0=0 (write) -> ACK_DEV, then SUB_HI.
  - Match, bit0=1 (read) -> ACK_DEV, then RD_DATA.
- SUB_HI / SUB_LO: each collects 8 bits.
  - reg_addr is loaded with the full 16-bit value at the 8th SUB_LO bit.
  - Both go through their ACK state.
- WR_DATA: at the 8th sampled bit, reg_wdata is set to that byte.
  - reg_we pulses for exactly one cycle, the cycle after that sample.
  - Then ACK_WR; further bytes in the same transaction write to reg_addr+1.
  - Pointer wraps 16'hFFFF -> 16'h0000.
- RD_DATA
  - On entry, a shift register loads reg_rdata.
  - sio_d_oe = ~shift[7], updated after each sio_c falling edge; bits 8 in total.
  - After the 8th falling edge the slave releases sio_d (RD_ACK).
- RD_ACK: the master's 9th bit is sampled.
  - 0: reg_addr increments (with wrap), return to RD_DATA.
  - 1 (NA): -> IGNORE.
- ACK states (ACK_DEV/HI/LO/WR): the 9th clock is the SCCB don't-care bit; see the optional feature for drive behaviour.
- IGNORE: sio_d_oe=0 and no strobes; wait for START or STOP.
- STOP in any state -> IDLE.
  - sio_d_oe=0, busy=0.
  - Partial bytes are discarded; no reg_we.
  - reg_addr is retained (the read phase uses the pointer set by the preceding write phase).
- Repeated START in any state -> DEV_ADDR, bit counter cleared, sio_d_oe=0.
- START/STOP in the same cycle as a bit sample: the bus condition wins.

Optional Feature:
- SCCB_SLAVE_ACK_DRIVE_EN defined: in ACK_DEV, ACK_HI, ACK_LO and ACK_WR the slave drives sio_d_oe=1 from the 8th falling edge to the 9th falling edge (I2C-style ACK).
- Undefined: sio_d_oe stays 0 in ACK states (pure SCCB don't-care bit).
- RD_ACK never drives in either case.

Decomposition:
- Package sccb_pkg:
  - state enum
  - SCCB_DIR_WRITE=1'b0, SCCB_DIR_READ=1'b1
  - SCCB_SUBADDR_W=16
  - SCCB_BYTE_BITS=8
- Sub-module sccb_sync_edge (synchroniser plus rise/fall pulse outputs), instantiated for sio_c and for sio_d.

Test Plan:
- Write 0x1C/W (byte 0x38), sub 0x1234, data 0xAA, STOP -> exactly one reg_we pulse with reg_addr=0x1234, reg_wdata=0xAA; busy low after STOP.
- Write phase 0x38, 0x12, 0x34, STOP; then START, 0x39, with reg_rdata=0x5A -> sio_d_oe pattern 1,0,1,0,0,1,0,1 (sio_d = 01011010); master NA -> IGNORE, sio_d_oe=0.
- Device byte 0x42 (address 0x21) -> no reg_we, sio_d_oe never asserts, busy drops at STOP.
- Sub 0xFFFF, data 0x11, 0x22 -> writes at 0xFFFF (0x11) then 0x0000 (0x22).
- STOP after 4 bits of SUB_LO -> IDLE, no reg_we, reg_addr keeps its prior value.
- reset=1 during RD_DATA with sio_d_oe=1 -> sio_d_oe=0 and busy=0 on the next clk edge; a following full write succeeds.
